// File: rtl/sound_i2s_tx.sv
// -----------------------------------------------------------------------------
// sound_i2s_tx
//
// Serialises the stereo mixer output into a Philips I2S stream for an
// external audio DAC. bclk and lrck are derived from clk by a simple divider.
// Both channel words are latched together at each frame boundary, so the left
// and right halves of a frame always come from the same clk cycle.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   left        left sample, sampled only at frame start
//   right       right sample, sampled only at frame start
//   en          0 = mute (zeros latched instead of samples), clocks keep running
//   bclk        I2S bit clock (50% duty, BCLK_DIV clk per half-period)
//   lrck        word select, 0 = left slot, 1 = right slot
//   sdata       serial data, MSB first, changes with bclk falling
//   sample_req  one-clk pulse in the cycle the samples were latched
// -----------------------------------------------------------------------------
module sound_i2s_tx #(
  parameter int BCLK_DIV  = 2,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] left,
  input  logic [DATA_BITS-1:0] right,
  input  logic                 en,
  output logic                 bclk,
  output logic                 lrck,
  output logic                 sdata,
  output logic                 sample_req
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int POS_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_BITS - 1);
  localparam logic [POS_W-1:0] SLOT_N   = POS_W'(SLOT_BITS);
  localparam logic [POS_W-1:0] DATA_N   = POS_W'(DATA_BITS);

  logic [DIV_W-1:0]     div_cnt_q;
  logic                 bclk_q;
  logic                 lrck_q;
  logic                 sdata_q;
  logic                 sample_req_q;
  logic [POS_W-1:0]     pos_q;
  logic [DATA_BITS-1:0] hold_l_q;
  logic [DATA_BITS-1:0] hold_r_q;

  logic                 div_tc;
  logic                 fall_evt;
  logic [POS_W-1:0]     pos_d;
  logic                 lrck_d;
  logic [POS_W-1:0]     slot_k;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] word_sel;
  logic                 sdata_d;

  // Divider terminal count; a toggle while bclk is high is a falling edge,
  // which is the only edge that moves the frame position.
  assign div_tc   = (div_cnt_q == DIV_LAST);
  assign fall_evt = div_tc && bclk_q;

  // Next frame position and the outputs it implies. Everything here is
  // computed from the position we are about to enter, so the registered
  // outputs line up with pos_q after the fall edge.
  always_comb begin
    pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    lrck_d   = (pos_d >= SLOT_N);
    slot_k   = lrck_d ? (pos_d - SLOT_N) : pos_d;
    word_sel = lrck_d ? hold_r_q : hold_l_q;
    // Bit 1 of the slot carries the MSB; bit 0 is the one-bit I2S delay.
    bit_idx  = IDX_W'(DATA_N - slot_k);
    sdata_d  = 1'b0;
    if ((slot_k != '0) && (slot_k <= DATA_N)) begin
      sdata_d = word_sel[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
      // Parked on the last position so the first fall wraps to 0 and the
      // first frame starts immediately.
      pos_q        <= POS_LAST;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
    end else begin
      div_cnt_q    <= div_tc ? '0 : div_cnt_q + DIV_W'(1);
      sample_req_q <= 1'b0;
      if (div_tc) begin
        bclk_q <= ~bclk_q;
      end
      if (fall_evt) begin
        pos_q   <= pos_d;
        lrck_q  <= lrck_d;
        sdata_q <= sdata_d;
        // Frame boundary: latch both words together. sdata on this edge is
        // the delay bit (always 0), so the fresh hold values are first used
        // on the following fall and no bypass path is needed.
        if (pos_d == '0) begin
          hold_l_q     <= en ? left  : '0;
          hold_r_q     <= en ? right : '0;
          sample_req_q <= 1'b1;
        end
      end
    end
  end

  assign bclk       = bclk_q;
  assign lrck       = lrck_q;
  assign sdata      = sdata_q;
  assign sample_req = sample_req_q;

endmodule

// File: tb/tb_sound_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_sound_i2s_tx
//
// Two transmitters share the same inputs: one with the default bclk divider
// and one with BCLK_DIV=1. A reference process keeps a count of clk edges
// since reset and, at each frame boundary predicted from that count, turns the
// sampled inputs into the 64 expected (lrck, sdata) pairs of the frame and
// queues them. A monitor pops one pair on every observed bclk rising edge and
// also checks bclk and sample_req against the edge count every cycle.
// -----------------------------------------------------------------------------
module tb_sound_i2s_tx;

  localparam int SLOT = 32;
  localparam int DATA = 20;
  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic [DATA-1:0] left  = '0;
  logic [DATA-1:0] right = '0;
  logic            en    = 1'b0;

  logic [1:0] bclk_w, lrck_w, sdata_w, sreq_w;

  sound_i2s_tx #(.BCLK_DIV(DIV0), .SLOT_BITS(SLOT), .DATA_BITS(DATA)) dut0 (
    .clk(clk), .rst(rst), .left(left), .right(right), .en(en),
    .bclk(bclk_w[0]), .lrck(lrck_w[0]), .sdata(sdata_w[0]), .sample_req(sreq_w[0])
  );

  sound_i2s_tx #(.BCLK_DIV(DIV1), .SLOT_BITS(SLOT), .DATA_BITS(DATA)) dut1 (
    .clk(clk), .rst(rst), .left(left), .right(right), .en(en),
    .bclk(bclk_w[1]), .lrck(lrck_w[1]), .sdata(sdata_w[1]), .sample_req(sreq_w[1])
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;     // clk edges since rst was last sampled high
  bit         armed = 1'b0;
  logic [1:0] prev_b = 2'b00;
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  // Frames start at the first bclk fall (2*div edges) and repeat every
  // 2*SLOT bit periods of 2*div clk each.
  function automatic bit is_cap(input int i, input int c);
    int d;
    d = div_of(i);
    return (c >= 2 * d) && (((c - 2 * d) % (4 * SLOT * d)) == 0);
  endfunction

  function automatic int pos_of(input int i, input int c);
    int falls;
    falls = c / (2 * div_of(i));
    return (falls == 0) ? (2 * SLOT - 1) : ((falls - 1) % (2 * SLOT));
  endfunction

  task automatic chk(input string name, input int inst, input logic [1:0] act,
                     input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc=%0d got=%b want=%b", name, inst, cyc, act, exp);
    end
  endtask

  // Expected frame: per slot, a zero delay bit, the word MSB first, then padding.
  task automatic push_frame(input int i);
    logic [DATA-1:0] w;
    logic            b;
    logic [1:0]      e;
    for (int s = 0; s < 2; s++) begin
      w = en ? ((s == 0) ? left : right) : '0;
      for (int k = 0; k < SLOT; k++) begin
        b = (k >= 1 && k <= DATA) ? w[DATA-k] : 1'b0;
        e = {(s == 1), b};
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  // Reference: track edges and queue expected frames at predicted boundaries.
  always @(posedge clk) begin
    if (rst) begin
      cyc   = 0;
      armed = 1'b1;
      q0.delete();
      q1.delete();
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (is_cap(i, cyc)) push_frame(i);
      end
    end
  end

  task automatic check_inst(input int i);
    int         d;
    logic [1:0] e;
    d = div_of(i);
    chk("bclk", i, {1'b0, bclk_w[i]}, {1'b0, (((cyc / d) % 2) == 1)});
    chk("sample_req", i, {1'b0, sreq_w[i]}, {1'b0, is_cap(i, cyc)});
    if (cyc == 0) chk("reset_lrck_sdata", i, {lrck_w[i], sdata_w[i]}, 2'b00);
    if (bclk_w[i] && !prev_b[i]) begin
      e = 2'b00;  // before the first capture both outputs sit at reset value
      if (i == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (i == 1 && q1.size() > 0) e = q1.pop_front();
      chk("lrck_sdata", i, {lrck_w[i], sdata_w[i]}, e);
    end
    prev_b[i] = bclk_w[i];
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) check_inst(i);
    end
  end

  // Wait (bounded) until the default-divider instance sits at frame position p.
  task automatic wait_pos(input int p);
    int t;
    t = 0;
    @(negedge clk);
    while (pos_of(0, cyc) != p && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pos got=timeout want=pos%0d", p);
    end
  endtask

  initial begin
    // Reset held for 5 clk with random inputs.
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      left  = DATA'($urandom);
      right = DATA'($urandom);
      en    = 1'($urandom);
    end
    // Directed data-format frame, present at the first capture.
    left  = 20'hA5A5A;
    right = 20'h0F0F1;
    en    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (260) @(negedge clk);

    // Mid-frame input change must not disturb the latched frame.
    left = 20'hFFFFF;
    wait_pos(63);
    wait_pos(40);
    left = 20'h00001;
    wait_pos(63);
    wait_pos(40);

    // Mute for a full frame, then resume.
    en = 1'b0;
    wait_pos(63);
    wait_pos(62);
    en = 1'b1;
    left  = DATA'($urandom);
    right = DATA'($urandom);
    wait_pos(63);
    wait_pos(62);

    // Randomised inputs changing at arbitrary times.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        left  = DATA'($urandom);
        right = DATA'($urandom);
        en    = ($urandom_range(0, 3) != 0);
      end
    end

    // Reset in the middle of a left slot; frames must restart from pos 0.
    wait_pos(17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (700) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) begin
        left  = DATA'($urandom);
        right = DATA'($urandom);
        en    = 1'($urandom);
      end
    end

    // bclk must have kept draining the expected queues.
    chk("q_depth", 0, {1'b0, (q0.size() <= 2 * SLOT)}, 2'b01);
    chk("q_depth", 1, {1'b0, (q1.size() <= 2 * SLOT)}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
